// File: rtl/sqrt_arbiter.sv
// Round-robin front end that shares one iterative integer square-root engine among
// NUM_REQ clients, with a watchdog on the engine's completion pulse.

module sqrt_arbiter_chk #(
   parameter int NUM_REQ = 4
) (
   input logic               clk,
   input logic               rst,
   input logic [NUM_REQ-1:0] req_ready,
   input logic [NUM_REQ-1:0] rsp_valid,
   input logic               eng_start,
   input logic               busy
);
   a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
   a_rsp_onehot:   assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid));
   a_start_pulse:  assert property (@(posedge clk) disable iff (rst) eng_start |=> !eng_start);
   a_rsp_pulse:    assert property (@(posedge clk) disable iff (rst) (|rsp_valid) |=> !(|rsp_valid));
   a_ready_idle:   assert property (@(posedge clk) disable iff (rst) (|req_ready) |-> !busy);
endmodule

module sqrt_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int RES_W   = DATA_W / 2,
   parameter int TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_x,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [RES_W-1:0]          rsp_result,
   output logic                      rsp_error,
   output logic                      eng_start,
   output logic [DATA_W-1:0]         eng_x,
   input  logic                      eng_done,
   input  logic [RES_W-1:0]          eng_result,
   output logic                      busy
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int TMR_W = $clog2(TIMEOUT);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W+1)'(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v = {NUM_REQ{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         v[i] = (idx == IDX_W'(i));
      end
      return v;
   endfunction

   state_t             state_r, state_s;
   logic [IDX_W-1:0]   last_grant_r, last_grant_s;
   logic [IDX_W-1:0]   idx_r, idx_s;
   logic [DATA_W-1:0]  x_r, x_s;
   logic [RES_W-1:0]   result_r, result_s;
   logic               error_r, error_s;
   logic [TMR_W-1:0]   timer_r, timer_s;
   logic [NUM_REQ-1:0] rsp_valid_r;
   logic               eng_start_r;
   logic               busy_r;

   logic [DATA_W-1:0]  req_x_s [NUM_REQ];
   logic [DATA_W-1:0]  sel_x_s;
   logic [IDX_W-1:0]   winner_s;
   logic [IDX_W-1:0]   cand_s;
   logic [IDX_W:0]     cand_raw_s;
   logic               any_s;
   logic [NUM_REQ-1:0] req_ready_s;

   // Unpack the flat operand bus into one word per requester.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_x_s[i] = req_x[i*DATA_W +: DATA_W];
      end
   end

   // Round-robin pick: scan from last_grant+1 with wrap; the lowest offset is written last and wins.
   always_comb begin
      any_s      = |req_valid;
      winner_s   = last_grant_r;
      cand_raw_s = {(IDX_W+1){1'b0}};
      cand_s     = {IDX_W{1'b0}};
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand_raw_s = {1'b0, last_grant_r} + (IDX_W+1)'(i + 1);
         cand_s     = (cand_raw_s >= NUM_EXT) ? IDX_W'(cand_raw_s - NUM_EXT) : cand_raw_s[IDX_W-1:0];
         winner_s   = req_valid[cand_s] ? cand_s : winner_s;
      end
      sel_x_s = req_x_s[winner_s];
   end

   // Grant decode; held low while reset is asserted so nothing is accepted during reset.
   always_comb begin
      req_ready_s = {NUM_REQ{1'b0}};
      if ((state_r == IDLE) && any_s && !rst) begin
         req_ready_s = onehot(winner_s);
      end else begin
         req_ready_s = {NUM_REQ{1'b0}};
      end
   end

   // Next-state and datapath-register update logic.
   always_comb begin
      state_s      = state_r;
      last_grant_s = last_grant_r;
      idx_s        = idx_r;
      x_s          = x_r;
      result_s     = result_r;
      error_s      = error_r;
      timer_s      = timer_r;
      case (state_r)
         IDLE: begin
            if (any_s) begin
               idx_s        = winner_s;
               last_grant_s = winner_s;
               x_s          = sel_x_s;
               // Operands 0 and 1 are their own square root; skip the engine.
               if (~|sel_x_s[DATA_W-1:1]) begin
                  result_s = sel_x_s[RES_W-1:0];
                  error_s  = 1'b0;
                  state_s  = RESP;
               end else begin
                  state_s  = START;
               end
            end else begin
               state_s = IDLE;
            end
         end
         START: begin
            timer_s = {TMR_W{1'b0}};
            state_s = WAIT;
         end
         WAIT: begin
            if (eng_done) begin
               result_s = eng_result;
               error_s  = 1'b0;
               state_s  = RESP;
            end else if (timer_r == TMR_LAST) begin
               result_s = {RES_W{1'b0}};
               error_s  = 1'b1;
               state_s  = RESP;
            end else begin
               timer_s  = timer_r + TMR_W'(1);
            end
         end
         RESP: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, datapath and output registers; outputs are derived from next-state values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         last_grant_r <= LAST_IDX;
         idx_r        <= {IDX_W{1'b0}};
         x_r          <= {DATA_W{1'b0}};
         result_r     <= {RES_W{1'b0}};
         error_r      <= 1'b0;
         timer_r      <= {TMR_W{1'b0}};
         rsp_valid_r  <= {NUM_REQ{1'b0}};
         eng_start_r  <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         last_grant_r <= last_grant_s;
         idx_r        <= idx_s;
         x_r          <= x_s;
         result_r     <= result_s;
         error_r      <= error_s;
         timer_r      <= timer_s;
         rsp_valid_r  <= (state_s == RESP) ? onehot(idx_s) : {NUM_REQ{1'b0}};
         eng_start_r  <= (state_s == START);
         busy_r       <= (state_s != IDLE);
      end
   end

   assign req_ready  = req_ready_s;
   assign rsp_valid  = rsp_valid_r;
   assign rsp_result = result_r;
   assign rsp_error  = error_r;
   assign eng_start  = eng_start_r;
   assign eng_x      = x_r;
   assign busy       = busy_r;

   sqrt_arbiter_chk #(
      .NUM_REQ(NUM_REQ)
   ) u_chk (
      .clk       (clk),
      .rst       (rst),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .eng_start (eng_start),
      .busy      (busy)
   );
endmodule

// File: tb/tb_sqrt_arbiter.sv
// Bench for sqrt_arbiter: stub engine with programmable latency, grant checks,
// and a response scoreboard with latency measured from the grant cycle.
module tb_sqrt_arbiter;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int RW = 16;
   localparam int TO = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_x;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    rsp_valid;
   logic [RW-1:0]   rsp_result;
   logic            rsp_error;
   logic            eng_start;
   logic [DW-1:0]   eng_x;
   logic            eng_done;
   logic [RW-1:0]   eng_result;
   logic            busy;

   sqrt_arbiter #(.NUM_REQ(N), .DATA_W(DW), .RES_W(RW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_error(rsp_error),
      .eng_start(eng_start), .eng_x(eng_x), .eng_done(eng_done), .eng_result(eng_result),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]  vld;
      logic [RW-1:0] res;
      logic          err;
      int            lat;
      int            gcyc;
   } exp_t;

   typedef struct {
      int            idx;
      logic [DW-1:0] x;
      int            dly;
      logic          fen;
      logic [RW-1:0] fval;
      logic [RW-1:0] res;
      logic          err;
      int            lat;
      int            starts;
   } vec_t;

   exp_t          sb[$];
   exp_t          mon_e;
   int            tests = 0;
   int            fails = 0;
   int            cyc = 0;
   int            rsp_cnt = 0;
   int            start_cnt = 0;
   int            eng_delay = 1;
   int            eng_cnt = 0;
   logic          eng_force = 1'b0;
   logic [RW-1:0] eng_fval = '0;
   logic [RW-1:0] eng_val = '0;
   logic [DW-1:0] exp_eng_x = '0;

   function automatic logic [RW-1:0] isqrt(input logic [DW-1:0] x);
      logic [RW-1:0] r;
      logic [RW-1:0] t;
      logic [63:0]   sq;
      r = '0;
      for (int b = RW - 1; b >= 0; b--) begin
         t = r;
         t[b] = 1'b1;
         sq = 64'(t) * 64'(t);
         if (sq <= 64'(x)) r = t;
      end
      return r;
   endfunction

   task automatic check(input logic ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Stub engine: responds eng_delay cycles after the start pulse (0 = never).
   initial begin
      eng_done = 1'b0;
      eng_result = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            eng_done = 1'b0;
            eng_cnt = 0;
         end else begin
            eng_done = 1'b0;
            if (eng_cnt == 1) begin
               eng_done = 1'b1;
               eng_result = eng_val;
            end
            if (eng_cnt > 0) eng_cnt--;
            if (eng_start) begin
               start_cnt++;
               check(eng_x == exp_eng_x, "eng_x", 64'(eng_x), 64'(exp_eng_x));
               eng_cnt = eng_delay;
               eng_val = eng_force ? eng_fval : isqrt(eng_x);
            end
         end
      end
   end

   // Response monitor / scoreboard.
   initial forever begin
      @(negedge clk);
      if (!rst && rsp_valid != '0) begin
         rsp_cnt++;
         if (sb.size() == 0) begin
            check(1'b0, "unexpected_rsp", 64'({rsp_valid, rsp_result, rsp_error}), 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check({rsp_valid, rsp_result, rsp_error, 8'(cyc - mon_e.gcyc)} ==
                  {mon_e.vld, mon_e.res, mon_e.err, 8'(mon_e.lat)},
                  "rsp{valid,result,error,latency}",
                  64'({rsp_valid, rsp_result, rsp_error, 8'(cyc - mon_e.gcyc)}),
                  64'({mon_e.vld, mon_e.res, mon_e.err, 8'(mon_e.lat)}));
         end
      end
   end

   // Called just after a negedge with requests driven: waits for the grant and checks it.
   task automatic grant(input int idx, input logic [DW-1:0] x, input logic push,
                        input logic [RW-1:0] res, input logic err, input int lat);
      int n;
      exp_t e;
      logic [N-1:0] want;
      n = 0;
      want = '0;
      want[idx] = 1'b1;
      while (req_ready == '0 && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      check(req_ready == want, "grant", 64'(req_ready), 64'(want));
      if (push) begin
         e.vld = want; e.res = res; e.err = err; e.lat = lat; e.gcyc = cyc;
         sb.push_back(e);
      end
      exp_eng_x = x;
      @(posedge clk);
      #1;
      req_valid[idx] = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check(sb.size() == 0, "drain_pending", 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   task automatic serve(input vec_t v);
      int s0;
      eng_delay = v.dly;
      eng_force = v.fen;
      eng_fval  = v.fval;
      @(negedge clk);
      req_valid[v.idx] = 1'b1;
      req_x[v.idx*DW +: DW] = v.x;
      #1;
      s0 = start_cnt;
      grant(v.idx, v.x, 1'b1, v.res, v.err, v.lat);
      drain();
      check(start_cnt - s0 == v.starts, "eng_start_count", 64'(start_cnt - s0), 64'(v.starts));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[9];
      vec_t late;
      logic [DW-1:0] cont_x [N];
      logic [RW-1:0] cont_r [N];
      int c0;

      //         idx  x             dly fen   fval   res        err   lat starts
      vecs[0] = '{2, 32'd144,        2, 1'b0, 16'd0, 16'd12,    1'b0, 4,  1};
      vecs[1] = '{1, 32'd0,          1, 1'b0, 16'd0, 16'd0,     1'b0, 1,  0};
      vecs[2] = '{1, 32'd1,          1, 1'b0, 16'd0, 16'd1,     1'b0, 1,  0};
      vecs[3] = '{3, 32'd2,          1, 1'b0, 16'd0, 16'd1,     1'b0, 3,  1};
      vecs[4] = '{0, 32'hFFFF_FFFF,  3, 1'b0, 16'd0, 16'hFFFF,  1'b0, 5,  1};
      vecs[5] = '{1, 32'd100,        0, 1'b0, 16'd0, 16'd0,     1'b1, 10, 1};
      vecs[6] = '{2, 32'd100,        8, 1'b1, 16'd7, 16'd7,     1'b0, 10, 1};
      vecs[7] = '{3, 32'd50,         7, 1'b0, 16'd0, 16'd7,     1'b0, 9,  1};
      vecs[8] = '{0, 32'd3,          1, 1'b0, 16'd0, 16'd1,     1'b0, 3,  1};
      late    = '{1, 32'd100,       10, 1'b0, 16'd0, 16'd0,     1'b1, 10, 1};
      cont_x = '{32'd4, 32'd9, 32'd16, 32'd25};
      cont_r = '{16'd2, 16'd3, 16'd4, 16'd5};

      // Reset with all four clients already requesting.
      req_valid = 4'hF;
      req_x = {32'd25, 32'd16, 32'd9, 32'd4};
      #1 rst = 1'b1;
      #1;
      check({req_ready, rsp_valid, rsp_result, rsp_error, eng_start, eng_x, busy} == '0,
            "reset_state", 64'({req_ready, rsp_valid, rsp_result, rsp_error, eng_start, eng_x, busy}), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;

      // Contention: grants 0,1,2,3 in order.
      eng_delay = 1;
      for (int k = 0; k < N; k++) grant(k, cont_x[k], 1'b1, cont_r[k], 1'b0, 3);
      drain();

      // After last_grant=3, requesters 0 and 3 together: 0 wins, then 3.
      @(negedge clk);
      req_valid = 4'b1001;
      req_x[0*DW +: DW] = 32'd49;
      req_x[3*DW +: DW] = 32'd64;
      #1;
      grant(0, 32'd49, 1'b1, 16'd7, 1'b0, 3);
      grant(3, 32'd64, 1'b1, 16'd8, 1'b0, 3);
      drain();

      // Timeout, then a stale done pulse that must be ignored.
      serve(late);
      c0 = rsp_cnt;
      repeat (6) @(negedge clk);
      check(rsp_cnt == c0, "late_done_ignored", 64'(rsp_cnt), 64'(c0));
      check(busy == 1'b0, "idle_after_late_done", 64'(busy), 64'd0);

      for (int i = 0; i < 9; i++) serve(vecs[i]);

      // Reset two cycles after eng_start while waiting on the engine.
      eng_delay = 0;
      eng_force = 1'b0;
      @(negedge clk);
      req_valid[2] = 1'b1;
      req_x[2*DW +: DW] = 32'd144;
      #1;
      grant(2, 32'd144, 1'b0, 16'd0, 1'b0, 0);
      @(posedge clk);
      @(posedge clk);
      #2;
      check(busy == 1'b1, "busy_in_wait", 64'(busy), 64'd1);
      rst = 1'b1;
      req_valid = 4'b1001;
      req_x[0*DW +: DW] = 32'd9;
      req_x[3*DW +: DW] = 32'd16;
      #1;
      check({req_ready, rsp_valid, rsp_result, rsp_error, eng_start, eng_x, busy} == '0,
            "async_reset", 64'({req_ready, rsp_valid, rsp_result, rsp_error, eng_start, eng_x, busy}), 64'd0);
      c0 = rsp_cnt;
      repeat (3) @(negedge clk);
      eng_delay = 1;
      rst = 1'b0;
      #1;
      grant(0, 32'd9, 1'b1, 16'd3, 1'b0, 3);
      grant(3, 32'd16, 1'b1, 16'd4, 1'b0, 3);
      drain();
      check(rsp_cnt == c0 + 2, "rsp_count_after_reset", 64'(rsp_cnt), 64'(c0 + 2));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
